// File: rtl/barrier_actuator_pkg.sv
// Shared definitions for the barrier actuator: command encoding,
// actuator state encoding and the output bundle.
package barrier_actuator_pkg;

    localparam logic CTRL_UP   = 1'b1;
    localparam logic CTRL_DOWN = 1'b0;

    typedef enum logic [2:0] {
        ST_CHECK    = 3'd0,
        ST_UP       = 3'd1,
        ST_WARN     = 3'd2,
        ST_LOWERING = 3'd3,
        ST_DOWN     = 3'd4,
        ST_RAISING  = 3'd5,
        ST_FAULT    = 3'd6
    } act_state_e;

    typedef struct packed {
        logic motor_up;
        logic motor_down;
        logic lamp;
        logic bell;
        logic at_up;
        logic at_down;
        logic fault;
    } act_out_t;

    function automatic logic is_moving(input act_state_e s);
        return (s == ST_LOWERING) || (s == ST_RAISING);
    endfunction

endpackage

// File: rtl/barrier_actuator_blink_gen.sv
// Free-running lamp blink phase generator; phase toggles
// every BLINK_HALF cycles and starts at 0 out of reset.
module blink_gen #(
    parameter int BLINK_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    output logic phase
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + BW'(1);
        phase_d = phase_q;
        if (cnt_q == LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/barrier_actuator.sv
// Barrier actuator: turns the barrier_ctrl level into lamp, bell
// and motor drive using the limit switches; reports status and fault.
module barrier_actuator
    import barrier_actuator_pkg::*;
#(
    parameter int WARN_CYCLES  = 16,
    parameter int MOVE_TIMEOUT = 64,
    parameter int BLINK_HALF   = 4,
    parameter int CW           = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic barrier_ctrl,
    input  logic lim_up,
    input  logic lim_down,
    output logic motor_up,
    output logic motor_down,
    output logic lamp,
    output logic bell,
    output logic at_up,
    output logic at_down,
    output logic fault
);

    localparam logic [CW-1:0] WARN_LAST = CW'(WARN_CYCLES - 1);
    localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TIMEOUT - 1);

    act_state_e    state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          phase;
    act_out_t      out;

    blink_gen #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .phase(phase)
    );

    always_comb begin
        state_d = state_q;
        if (state_q != ST_FAULT && lim_up && lim_down) begin
            state_d = ST_FAULT;
        end else if (is_moving(state_q) && timer_q == MOVE_LAST) begin
            state_d = ST_FAULT;
        end else begin
            unique case (state_q)
                ST_CHECK:    state_d = lim_up ? ST_UP : ST_RAISING;
                ST_UP:
                    if (barrier_ctrl == CTRL_DOWN) state_d = ST_WARN;
                ST_WARN:
                    if (barrier_ctrl == CTRL_UP)   state_d = ST_UP;
                    else if (timer_q == WARN_LAST) state_d = ST_LOWERING;
                ST_LOWERING:
                    if (lim_down)                  state_d = ST_DOWN;
                    else if (barrier_ctrl == CTRL_UP) state_d = ST_RAISING;
                ST_DOWN:
                    if (barrier_ctrl == CTRL_UP)   state_d = ST_RAISING;
                ST_RAISING:
                    if (lim_up)                    state_d = ST_UP;
                    else if (barrier_ctrl == CTRL_DOWN) state_d = ST_LOWERING;
                ST_FAULT:    state_d = ST_FAULT;
                default:     state_d = ST_FAULT;
            endcase
        end
    end

    // One timer serves both the warning and movement phases
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)  timer_d = '0;
        else if (timer_q != '1)  timer_d = timer_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CHECK;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        out = '0;
        unique case (state_q)
            ST_CHECK:    out = '0;
            ST_UP:       out.at_up = 1'b1;
            ST_WARN: begin
                out.lamp = phase;
                out.bell = 1'b1;
            end
            ST_LOWERING: begin
                out.motor_down = 1'b1;
                out.lamp       = phase;
                out.bell       = 1'b1;
            end
            ST_DOWN: begin
                out.at_down = 1'b1;
                out.lamp    = phase;
            end
            ST_RAISING: begin
                out.motor_up = 1'b1;
                out.lamp     = phase;
            end
            ST_FAULT: begin
                out.fault = 1'b1;
                out.lamp  = 1'b1;
            end
            default:     out = '0;
        endcase
    end

    assign motor_up   = out.motor_up;
    assign motor_down = out.motor_down;
    assign lamp       = out.lamp;
    assign bell       = out.bell;
    assign at_up      = out.at_up;
    assign at_down    = out.at_down;
    assign fault      = out.fault;

endmodule

// File: tb/tb_barrier_actuator.sv
// Scoreboard bench for barrier_actuator: directed scenarios then
// random stimulus, checked against a time-in-mode reference model.
module tb_barrier_actuator;

    localparam int WARN = 16;
    localparam int MT   = 64;
    localparam int BH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic barrier_ctrl = 1'b1;
    logic lim_up = 1'b1;
    logic lim_down = 1'b0;
    logic motor_up, motor_down, lamp, bell, at_up, at_down, fault;

    always #5 clk = ~clk;

    barrier_actuator #(
        .WARN_CYCLES (WARN),
        .MOVE_TIMEOUT(MT),
        .BLINK_HALF  (BH),
        .CW          (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .barrier_ctrl(barrier_ctrl),
        .lim_up      (lim_up),
        .lim_down    (lim_down),
        .motor_up    (motor_up),
        .motor_down  (motor_down),
        .lamp        (lamp),
        .bell        (bell),
        .at_up       (at_up),
        .at_down     (at_down),
        .fault       (fault)
    );

    typedef enum int {
        M_CHECK, M_UP, M_WARN, M_LOW, M_DOWN, M_RAISE, M_FAULT
    } mode_t;

    mode_t      mode  = M_CHECK;
    int         dwell = 0;
    int         ticks = 0;
    logic [6:0] sbq[$];
    int         checks   = 0;
    int         failures = 0;

    // {motor_up, motor_down, lamp, bell, at_up, at_down, fault}
    function automatic logic [6:0] model_out();
        logic ph;
        ph = ((ticks / BH) % 2) == 1;
        case (mode)
            M_UP:    return 7'b0000100;
            M_WARN:  return {2'b00, ph, 1'b1, 3'b000};
            M_LOW:   return {2'b01, ph, 1'b1, 3'b000};
            M_DOWN:  return {2'b00, ph, 1'b0, 3'b010};
            M_RAISE: return {2'b10, ph, 1'b0, 3'b000};
            M_FAULT: return 7'b0010001;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic mode_t model_next(input logic c, input logic u,
                                         input logic d);
        if (mode != M_FAULT && u && d) return M_FAULT;
        case (mode)
            M_CHECK: return u ? M_UP : M_RAISE;
            M_UP:    return c ? M_UP : M_WARN;
            M_WARN:
                if (c) return M_UP;
                else if (dwell == WARN - 1) return M_LOW;
                else return M_WARN;
            M_LOW:
                if (dwell == MT - 1) return M_FAULT;
                else if (d) return M_DOWN;
                else if (c) return M_RAISE;
                else return M_LOW;
            M_RAISE:
                if (dwell == MT - 1) return M_FAULT;
                else if (u) return M_UP;
                else if (!c) return M_LOW;
                else return M_RAISE;
            M_DOWN:  return c ? M_RAISE : M_DOWN;
            default: return M_FAULT;
        endcase
    endfunction

    task automatic step(input logic c, input logic u, input logic d,
                        input logic r);
        mode_t nm;
        @(negedge clk);
        rst = r;
        barrier_ctrl = c;
        lim_up = u;
        lim_down = d;
        if (!r) begin
            mode  = M_CHECK;
            dwell = 0;
            ticks = 0;
        end else begin
            nm = model_next(c, u, d);
            dwell = (nm != mode) ? 0 : dwell + 1;
            mode  = nm;
            ticks++;
        end
        sbq.push_back(model_out());
    endtask

    task automatic steps(input int n, input logic c, input logic u,
                         input logic d);
        for (int i = 0; i < n; i++) step(c, u, d, 1'b1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({motor_up, motor_down, lamp, bell, at_up, at_down, fault} != 7'b0)
        begin
            failures++;
            $display("FAIL async_reset got=%b exp=0000000",
                     {motor_up, motor_down, lamp, bell, at_up, at_down,
                      fault});
        end
        mode  = M_CHECK;
        dwell = 0;
        ticks = 0;
        sbq.push_back(model_out());
    endtask

    always @(posedge clk) begin
        logic [6:0] act, exp_v;
        #1;
        if (sbq.size() > 0) begin
            exp_v = sbq.pop_front();
            act = {motor_up, motor_down, lamp, bell, at_up, at_down, fault};
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL outputs t=%0t got=%b exp=%b",
                         $time, act, exp_v);
            end
            checks++;
            if (motor_up && motor_down) begin
                failures++;
                $display("FAIL motor_both t=%0t got=11 exp=not 11", $time);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic c, u, d, r;
        int   x;
        // Reset, homing straight to UP, then a full lower cycle
        do_reset();
        steps(4, 1'b1, 1'b1, 1'b0);
        steps(20, 1'b0, 1'b1, 1'b0);
        steps(8, 1'b0, 1'b0, 1'b0);
        steps(14, 1'b0, 1'b0, 1'b1);
        // Raise back up
        steps(6, 1'b1, 1'b0, 1'b0);
        steps(4, 1'b1, 1'b1, 1'b0);
        // Abort during warning
        steps(5, 1'b0, 1'b1, 1'b0);
        steps(6, 1'b1, 1'b1, 1'b0);
        // Reverse mid-lowering
        steps(17, 1'b0, 1'b1, 1'b0);
        steps(20, 1'b0, 1'b0, 1'b0);
        steps(5, 1'b1, 1'b0, 1'b0);
        steps(3, 1'b1, 1'b1, 1'b0);
        // Lower to DOWN, then raise with no limit until timeout
        steps(17, 1'b0, 1'b1, 1'b0);
        steps(5, 1'b0, 1'b0, 1'b0);
        steps(3, 1'b0, 1'b0, 1'b1);
        steps(70, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(i[0], 1'b0, 1'b0, 1'b1);
        // Homing from reset without lim_up, then both limits in DOWN
        do_reset();
        steps(3, 1'b1, 1'b0, 1'b0);
        steps(2, 1'b1, 1'b1, 1'b0);
        steps(17, 1'b0, 1'b1, 1'b0);
        steps(4, 1'b0, 1'b0, 1'b0);
        steps(3, 1'b0, 1'b0, 1'b1);
        steps(1, 1'b0, 1'b1, 1'b1);
        steps(4, 1'b0, 1'b0, 1'b1);
        // Both limits during WARN
        do_reset();
        steps(3, 1'b1, 1'b1, 1'b0);
        steps(5, 1'b0, 1'b1, 1'b0);
        steps(1, 1'b0, 1'b1, 1'b1);
        steps(3, 1'b1, 1'b1, 1'b0);
        // Async reset while lowering
        do_reset();
        steps(3, 1'b1, 1'b1, 1'b0);
        steps(20, 1'b0, 1'b1, 1'b0);
        steps(3, 1'b0, 1'b0, 1'b0);
        async_reset_check();
        steps(5, 1'b1, 1'b1, 1'b0);
        // Random traffic
        c = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) c = ~c;
            x = $urandom_range(0, 99);
            u = (x < 20) || (x == 99);
            d = (x >= 80);
            r = ($urandom_range(0, 199) != 0);
            step(c, u, d, r);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d exp=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
